// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory for the td4 core with a byte-stream loader
// that holds the core in reset while a new program is written from address 0.
module imem_loader #(
  parameter int            AW   = 4,
  parameter int            DW   = 8,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld_start,
  input  logic          i_ld_run,
  input  logic          i_ld_valid,
  input  logic [DW-1:0] i_ld_data,
  output logic          o_ld_ready,
  output logic          o_ld_done,
  output logic [DW-1:0] o_ld_sum,
  output logic          o_cpu_rst,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr;
  logic [DW-1:0] r_sum;
  logic          r_done, r_from_load;
  logic          w_acc, w_last;
  // a restart on the same edge wins over a byte being offered
  assign w_acc    = r_state == LOAD && i_ld_valid && !i_ld_start;
  assign w_last   = w_acc && &r_wptr;
  assign o_data   = r_mem[i_addr];
  assign o_ld_sum = r_sum;
  assign o_ld_done = r_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (i_ld_start)                         w_next = LOAD;
    else if (r_state == IDLE && i_ld_run)   w_next = RELEASE;
    else if (w_last)                        w_next = RELEASE;
    else if (r_state == RELEASE)            w_next = RUN;
  end
  always_comb begin
    o_cpu_rst  = r_state != RUN;
    o_ld_ready = r_state == LOAD;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr      <= '0;
      r_sum       <= '0;
      r_done      <= 1'b0;
      r_from_load <= 1'b0;
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= INIT;
    end else begin
      if (i_ld_start) begin
        r_wptr      <= '0;
        r_sum       <= '0;
        r_done      <= 1'b0;
        r_from_load <= 1'b0;
      end else if (w_acc) begin
        r_mem[r_wptr] <= i_ld_data;
        r_sum         <= r_sum ^ i_ld_data;
        r_wptr        <= r_wptr + 1'b1;
        if (w_last) r_from_load <= 1'b1;
      end else if (r_state == RELEASE && r_from_load) begin
        r_done <= 1'b1;
      end
    end
endmodule
